dnn_ctrl: RTL

Sequencing controller for the five-stage `dnn` datapath (4-input, 4-hidden, 2-output network). It accepts an input request and steps the shared 8-multiplier datapath through layer-1 (y4/y5, then y6/y7), ReLU capture, and output MAC. It drives `dnn_state`, holds the aggregated hidden-layer values fed back to the datapath, and issues the single-cycle `out_comp_ready_p5` strobe. The block sits beside `dnn` in the five-stage top and is the only driver of its control inputs.

---
 rtl/defines_pkg.sv | 21 ++
 rtl/dnn_ctrl_if.sv | 38 +++
 rtl/dnn_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/defines_pkg.sv
`default_nettype none
// ============================================================================
// Package : defines_pkg
// Brief   : Shared types for the dnn datapath and its sequencing controller.
// Rev     : 1.0  initial release
// ============================================================================
package defines_pkg;

   // Controller sequencing states; encoding 3'd7 is unused and treated as illegal
   typedef enum logic [2:0] {
      IDLE             = 3'd0,
      LAYER1_y4y5_MUL  = 3'd1,
      LAYER1_y6y7_MUL  = 3'd2,
      LAYER1_FINAL_ADD = 3'd3,
      RELU_CAPTURE     = 3'd4,
      OUTPUT_MUL       = 3'd5,
      OUTPUT_ADD       = 3'd6
   } dnn_state_t;

endpackage
`default_nettype wire

// File: rtl/dnn_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : dnn_ctrl_if
// Brief     : Request handshake, hidden-layer feedback and state bus between
//             the dnn datapath/source (master) and dnn_ctrl (slave).
// Rev       : 1.0  initial release
// ============================================================================
interface dnn_ctrl_if;
   import defines_pkg::*;

   logic                in_ready;
   logic                in_accept;
   logic                busy;
   dnn_state_t          dnn_state;
   logic signed [12:0]  y4_relu_p4;
   logic signed [12:0]  y5_relu_p4;
   logic signed [12:0]  y6_relu_p4;
   logic signed [12:0]  y7_relu_p4;
   logic signed [14:0]  y4_aggr_p4;
   logic signed [14:0]  y5_aggr_p4;
   logic signed [14:0]  y6_aggr_p4;
   logic signed [14:0]  y7_aggr_p4;
   logic                out_comp_ready_p5;

   modport master (
      output in_ready, y4_relu_p4, y5_relu_p4, y6_relu_p4, y7_relu_p4,
      input  in_accept, busy, dnn_state,
             y4_aggr_p4, y5_aggr_p4, y6_aggr_p4, y7_aggr_p4, out_comp_ready_p5
   );

   modport slave (
      input  in_ready, y4_relu_p4, y5_relu_p4, y6_relu_p4, y7_relu_p4,
      output in_accept, busy, dnn_state,
             y4_aggr_p4, y5_aggr_p4, y6_aggr_p4, y7_aggr_p4, out_comp_ready_p5
   );

endinterface
`default_nettype wire

// File: rtl/dnn_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dnn_ctrl
// Brief  : Sequencing controller for the five-stage dnn datapath. Steps the
//          shared multipliers through layer-1, ReLU capture and output MAC,
//          holds the hidden-layer values and strobes out_comp_ready_p5.
//          Optional macro DNN_CTRL_PERF_EN adds inference/stall counters.
// Rev    : 1.0  initial release
// ============================================================================
module dnn_ctrl
   import defines_pkg::*;
(
   input  wire logic   clk,
   input  wire logic   rst_n,
   dnn_ctrl_if.slave   bus
`ifdef DNN_CTRL_PERF_EN
   ,
   output logic [15:0] perf_infer_cnt,
   output logic [15:0] perf_stall_cnt
`endif
);

   dnn_state_t         state_q, state_d;
   logic signed [14:0] y4_aggr_q, y4_aggr_d;
   logic signed [14:0] y5_aggr_q, y5_aggr_d;
   logic signed [14:0] y6_aggr_q, y6_aggr_d;
   logic signed [14:0] y7_aggr_q, y7_aggr_d;
   logic               out_rdy_q, out_rdy_d;
   logic               accept;

   // Handshake decode and next-state sequencing; a new request can be taken
   // in OUTPUT_ADD so back-to-back inferences run with no idle gap
   always_comb begin
      accept  = bus.in_ready & ((state_q == IDLE) | (state_q == OUTPUT_ADD));
      state_d = IDLE;
      case (state_q)
         IDLE:             state_d = accept ? LAYER1_y4y5_MUL : IDLE;
         LAYER1_y4y5_MUL:  state_d = LAYER1_y6y7_MUL;
         LAYER1_y6y7_MUL:  state_d = LAYER1_FINAL_ADD;
         LAYER1_FINAL_ADD: state_d = RELU_CAPTURE;
         RELU_CAPTURE:     state_d = OUTPUT_MUL;
         OUTPUT_MUL:       state_d = OUTPUT_ADD;
         OUTPUT_ADD:       state_d = accept ? LAYER1_y4y5_MUL : IDLE;
         default:          state_d = IDLE;
      endcase
      // Strobe is registered so it lines up exactly with the OUTPUT_ADD state
      out_rdy_d = (state_d == OUTPUT_ADD);
   end

   // Hidden-layer capture: ReLU outputs are only valid during RELU_CAPTURE
   always_comb begin
      y4_aggr_d = y4_aggr_q;
      y5_aggr_d = y5_aggr_q;
      y6_aggr_d = y6_aggr_q;
      y7_aggr_d = y7_aggr_q;
      if (state_q == RELU_CAPTURE) begin
         // ReLU output is never negative, so zero-fill equals sign-extension
         y4_aggr_d = {2'b00, bus.y4_relu_p4};
         y5_aggr_d = {2'b00, bus.y5_relu_p4};
         y6_aggr_d = {2'b00, bus.y6_relu_p4};
         y7_aggr_d = {2'b00, bus.y7_relu_p4};
      end
   end

   // State, hidden values and strobe registers; reset aborts any inference
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         y4_aggr_q <= '0;
         y5_aggr_q <= '0;
         y6_aggr_q <= '0;
         y7_aggr_q <= '0;
         out_rdy_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         y4_aggr_q <= y4_aggr_d;
         y5_aggr_q <= y5_aggr_d;
         y6_aggr_q <= y6_aggr_d;
         y7_aggr_q <= y7_aggr_d;
         out_rdy_q <= out_rdy_d;
      end
   end

   assign bus.in_accept         = accept;
   assign bus.busy              = (state_q != IDLE);
   assign bus.dnn_state         = state_q;
   assign bus.y4_aggr_p4        = y4_aggr_q;
   assign bus.y5_aggr_p4        = y5_aggr_q;
   assign bus.y6_aggr_p4        = y6_aggr_q;
   assign bus.y7_aggr_p4        = y7_aggr_q;
   assign bus.out_comp_ready_p5 = out_rdy_q;

`ifdef DNN_CTRL_PERF_EN
   logic [15:0] infer_cnt_q, infer_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Free-running wrap-around counters: completed inferences, pending stalls
   always_comb begin
      infer_cnt_d = infer_cnt_q + {15'd0, (state_q == OUTPUT_ADD)};
      stall_cnt_d = stall_cnt_q + {15'd0, (bus.in_ready & ~accept)};
   end

   // Performance counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         infer_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         infer_cnt_q <= infer_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_infer_cnt = infer_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire
